// File: rtl/tdc_capture_array.sv
// Multi-channel delay-line TDC front end: per-channel tapped line, two-flop
// tap pipeline, first-arrival capture (coarse edge index + fine popcount),
// self-test launch and valid/ready result hand-off.

// Tapped delay line. "RCA" builds the line as the carry chain of all-ones
// plus din, so each sum tap is the inverted carry; "BUF" is a plain
// non-inverting chain.
module delay_line #(
  parameter int N       = 64,
  parameter     DL_TYPE = "RCA"
) (
  input  logic         din,
  output logic [N-1:0] taps
);
  logic [N-1:0] c;

  assign c[0] = din;

  if (DL_TYPE == "RCA") begin : g_rca
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign taps[i] = 1'b1 ^ c[i];
      if (i < N - 1) begin : g_nxt
        assign c[i+1] = 1'b1 & c[i];
      end
    end
  end else begin : g_buf
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign taps[i] = c[i];
      if (i < N - 1) begin : g_nxt
        assign c[i+1] = c[i];
      end
    end
  end
endmodule

// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// ARM    | evaluating stage-B samples with index >= 1 for first arrivals
// DONE   | result valid, waiting for res_ready
module tdc_capture_array #(
  parameter int N       = 64,
  parameter int CH      = 2,
  parameter     DL_TYPE = "RCA",
  parameter int TAP_INV = 1,
  parameter int CW      = 8,
  localparam int FW     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    hit,
  input  logic             start,
  input  logic             selftest,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH-1:0]    res_seen,
  output logic [CH*CW-1:0] res_coarse,
  output logic [CH*FW-1:0] res_fine
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_DONE} state_e;

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   launch_q, launch_d;

  logic [CH-1:0]         line_in;
  logic [CH-1:0][N-1:0]  taps_raw;
  logic [CH-1:0][N-1:0]  sta_q;
  logic [CH-1:0][N-1:0]  stb_q;
  logic [CH-1:0][FW-1:0] pop;

  // Index of the sample currently in stage B; one extra bit marks the
  // not-yet-valid (negative) indices right after arming.
  logic [CW:0] k_q, k_d;
  logic        eval;

  logic [CH-1:0]         seen_q, seen_d;
  logic [CH-1:0][CW-1:0] coarse_q, coarse_d;
  logic [CH-1:0][FW-1:0] fine_q, fine_d;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign line_in[c] = mode_q ? launch_q : hit[c];

    delay_line #(
      .N      (N),
      .DL_TYPE(DL_TYPE)
    ) u_dl (
      .din (line_in[c]),
      .taps(taps_raw[c])
    );
  end

  // Two-flop tap synchroniser; runs every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sta_q <= '0;
      stb_q <= '0;
    end else begin
      sta_q <= (TAP_INV != 0) ? ~taps_raw : taps_raw;
      stb_q <= sta_q;
    end
  end

  // Fine code is a plain ones count so bubbles in the thermometer code
  // cost at most their own weight.
  always_comb begin
    pop = '0;
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < N; i++) begin
        pop[c] = pop[c] + FW'(stb_q[c][i]);
      end
    end
  end

  assign eval = (state_q == S_ARM) && !k_q[CW] && (k_q[CW-1:0] != '0);

  // Next-state, capture and launch logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    launch_d = launch_q;
    k_d      = k_q;
    seen_d   = seen_q;
    coarse_d = coarse_q;
    fine_d   = fine_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARM;
          mode_d   = selftest;
          launch_d = selftest;
          k_d      = '1;
          seen_d   = '0;
          coarse_d = '1;
          fine_d   = '0;
        end
      end
      S_ARM: begin
        k_d = k_q + (CW + 1)'(1);
        if (eval) begin
          for (int c = 0; c < CH; c++) begin
            if (!seen_q[c] && stb_q[c][0]) begin
              seen_d[c]   = 1'b1;
              coarse_d[c] = k_q[CW-1:0];
              fine_d[c]   = pop[c];
            end
          end
          if ((&seen_d) || (&k_q[CW-1:0])) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d  = S_IDLE;
          launch_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      launch_q <= 1'b0;
      k_q      <= '0;
      seen_q   <= '0;
      coarse_q <= '0;
      fine_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      launch_q <= launch_d;
      k_q      <= k_d;
      seen_q   <= seen_d;
      coarse_q <= coarse_d;
      fine_q   <= fine_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign res_seen   = seen_q;
  assign res_coarse = coarse_q;
  assign res_fine   = fine_q;

endmodule
